// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and generator tables for the rate-1/2 convolutional frame path.
package conv_pkg;

   localparam int unsigned K_MIN = 3;
   localparam int unsigned K_MAX = 7;
   localparam int unsigned K_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_e;

   // Octal generator polynomials; bit (K-1-i) set means delay i is tapped.
   localparam logic [K_MAX-1:0] GEN_A [K_MIN:K_MAX] = '{7'o7, 7'o17, 7'o35, 7'o65, 7'o171};
   localparam logic [K_MAX-1:0] GEN_B [K_MIN:K_MAX] = '{7'o5, 7'o15, 7'o23, 7'o57, 7'o133};

   // A 3-bit K tops out at K_MAX, so only the lower bound needs checking.
   function automatic logic k_legal(input logic [K_W-1:0] k);
      return k >= K_W'(K_MIN);
   endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder datapath: (K_MAX-1)-bit delay line plus generator tap XOR for a selectable K.
module conv_enc_core
   import conv_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           shift_en_i,
   input  logic           clear_i,
   input  logic           u_i,
   input  logic [K_W-1:0] k_i,
   output logic [1:0]     sym_c
);

   localparam int unsigned SR_W = K_MAX - 1;

   logic [SR_W-1:0]  sr_q;
   logic [SR_W-1:0]  sr_d;
   logic [K_MAX-1:0] gen_a;
   logic [K_MAX-1:0] gen_b;
   logic [K_MAX-1:0] rev_a;
   logic [K_MAX-1:0] rev_b;
   logic [K_MAX-1:0] tap_a;
   logic [K_MAX-1:0] tap_b;
   logic [K_MAX-1:0] dly;

   // Reverse and right-align the generators so tap bit i lines up with delay i.
   always_comb begin
      gen_a = GEN_A[k_i];
      gen_b = GEN_B[k_i];
      rev_a = {<<{gen_a}};
      rev_b = {<<{gen_b}};
      tap_a = rev_a >> (K_W'(K_MAX) - k_i);
      tap_b = rev_b >> (K_W'(K_MAX) - k_i);
      dly   = {sr_q, u_i};
      sym_c = {^(dly & tap_a), ^(dly & tap_b)};
   end

   always_comb begin
      sr_d = sr_q;
      if (clear_i) begin
         sr_d = '0;
      end else if (shift_en_i) begin
         sr_d = {sr_q[SR_W-2:0], u_i};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder: K latch, data pass, K-1 zero tail bits.
// Optional CONV_FRAME_STATS_EN adds frame_cnt / sym_cnt statistics outputs.
module conv_frame_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned K_MAX = 7
`ifdef CONV_FRAME_STATS_EN
   , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [K_W-1:0] choose_constraint_length,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic           s_data,
   input  logic           s_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic [1:0]     m_data,
   output logic           m_last,
   output logic           busy,
   output logic           cfg_err
`ifdef CONV_FRAME_STATS_EN
   , output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] sym_cnt
`endif
);

   localparam int unsigned TAIL_W = $clog2(K_MAX);

   state_e            state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [TAIL_W-1:0] tail_q, tail_d;
   logic              m_valid_q, m_valid_d;
   logic [1:0]        m_data_q, m_data_d;
   logic              m_last_q, m_last_d;
   logic              busy_q, busy_d;
   logic              cfg_err_q, cfg_err_d;

   logic       slot_free;
   logic       data_adv;
   logic       tail_adv;
   logic       last_hs;
   logic       enc_shift;
   logic       enc_clear;
   logic       enc_u;
   logic [1:0] enc_sym;

   // Handshake and encoder control kept outside the FSM block to avoid a comb loop through the core.
   assign slot_free = ~m_valid_q | m_ready;
   assign s_ready   = (state_q == DATA) & slot_free;
   assign data_adv  = s_ready & s_valid;
   assign tail_adv  = (state_q == TAIL) & (tail_q != '0) & slot_free;
   assign last_hs   = m_valid_q & m_ready & m_last_q;
   assign enc_shift = data_adv | tail_adv;
   assign enc_clear = (state_q == IDLE) & s_valid;
   assign enc_u     = (state_q == DATA) & s_data;

   conv_enc_core u_enc (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (enc_shift),
      .clear_i    (enc_clear),
      .u_i        (enc_u),
      .k_i        (k_q),
      .sym_c      (enc_sym)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      tail_d    = tail_q;
      m_valid_d = m_valid_q & ~m_ready;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q & ~m_ready;
      cfg_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s_valid) begin
               state_d = DATA;
               if (k_legal(choose_constraint_length)) begin
                  k_d = choose_constraint_length;
               end else begin
                  k_d       = K_W'(K_MIN);
                  cfg_err_d = 1'b1;
               end
            end
         end
         DATA: begin
            if (data_adv) begin
               m_valid_d = 1'b1;
               m_data_d  = enc_sym;
               m_last_d  = 1'b0;
               if (s_last) begin
                  state_d = TAIL;
                  tail_d  = TAIL_W'(k_q - K_W'(1));
               end
            end
         end
         TAIL: begin
            if (tail_adv) begin
               m_valid_d = 1'b1;
               m_data_d  = enc_sym;
               m_last_d  = (tail_q == TAIL_W'(1));
               tail_d    = tail_q - TAIL_W'(1);
            end else if (last_hs) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         k_q       <= K_W'(K_MIN);
         tail_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         tail_q    <= tail_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign busy    = busy_q;
   assign cfg_err = cfg_err_q;

`ifdef CONV_FRAME_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q;
   logic [CNT_W-1:0] sym_cnt_q;

   // Frame count on the m_last handshake; symbol count per frame, cleared at frame start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_q <= '0;
         sym_cnt_q   <= '0;
      end else begin
         if (last_hs) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         end
         if (enc_clear) begin
            sym_cnt_q <= '0;
         end else if (m_valid_q && m_ready) begin
            sym_cnt_q <= sym_cnt_q + CNT_W'(1);
         end
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign sym_cnt   = sym_cnt_q;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: frame-level reference model feeds an expected-symbol queue.
`timescale 1ns/1ps
module tb_conv_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] choose_constraint_length = 3'd3;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic       s_data = 1'b0;
   logic       s_last = 1'b0;
   logic       m_valid;
   logic       m_ready = 1'b1;
   logic [1:0] m_data;
   logic       m_last;
   logic       busy;
   logic       cfg_err;
`ifdef CONV_FRAME_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] sym_cnt;
`endif

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [2:0] exp_q[$];
   int         rdy_mode = 0;
   bit         in_tail = 1'b0;
   bit         chk_idle = 1'b0;
   bit         hold_chk = 1'b0;
   logic [2:0] hold_val = 3'd0;
   int         cfg_seen = 0;
   int         cfg_exp = 0;
   int unsigned gen_a_t [8] = '{0, 0, 0, 'o7, 'o17, 'o35, 'o65, 'o171};
   int unsigned gen_b_t [8] = '{0, 0, 0, 'o5, 'o15, 'o23, 'o57, 'o133};

   conv_frame_ctrl dut (
      .clk                      (clk),
      .rst                      (rst),
      .choose_constraint_length (choose_constraint_length),
      .s_valid                  (s_valid),
      .s_ready                  (s_ready),
      .s_data                   (s_data),
      .s_last                   (s_last),
      .m_valid                  (m_valid),
      .m_ready                  (m_ready),
      .m_data                   (m_data),
      .m_last                   (m_last),
      .busy                     (busy),
      .cfg_err                  (cfg_err)
`ifdef CONV_FRAME_STATS_EN
      , .frame_cnt              (frame_cnt),
      .sym_cnt                  (sym_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
      end
   endfunction

   function automatic void fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", nm, $time);
   endfunction

   // Reference: full bit sequence (data + K-1 zeros); each symbol XORs the tapped past inputs.
   task automatic push_frame(input int k_sel, input bit bits[$]);
      int k;
      bit seq[$];
      bit a;
      bit b;
      k = (k_sel < 3) ? 3 : k_sel;
      seq = bits;
      repeat (k - 1) seq.push_back(1'b0);
      for (int n = 0; n < seq.size(); n++) begin
         a = 1'b0;
         b = 1'b0;
         for (int i = 0; i < k && i <= n; i++) begin
            if (gen_a_t[k][k-1-i]) a ^= seq[n-i];
            if (gen_b_t[k][k-1-i]) b ^= seq[n-i];
         end
         exp_q.push_back({a, b, (n == seq.size() - 1)});
      end
   endtask

   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_frame(input int k_sel, input bit bits[$], input int gap_max, input int cs_after);
      bit ok;
      push_frame(k_sel, bits);
      if (k_sel < 3) cfg_exp++;
      choose_constraint_length = 3'(k_sel);
      foreach (bits[j]) begin
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
               s_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_valid = 1'b1;
         s_data  = bits[j];
         s_last  = (j == bits.size() - 1);
         wait_accept(ok);
         if (!ok) fail("accept_timeout");
         @(posedge clk);
         #1;
         if (j == 0) begin
            choose_constraint_length = 3'(cs_after);
            chk("busy_active", 32'(busy), 32'd1);
         end
         if (s_last) in_tail = 1'b1;
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 500) begin
         @(posedge clk);
         c++;
      end
      if (exp_q.size() != 0) begin
         fail("drain_timeout");
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Sink readiness pattern: always ready, toggling, or random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: pops expected symbols on each output handshake and checks protocol side rules.
   always @(negedge clk) begin
      logic [2:0] e;
      if (!rst) begin
         hold_chk = 1'b0;
         chk_idle = 1'b0;
      end else begin
         if (chk_idle) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_s_ready", 32'(s_ready), 32'd0);
            chk_idle = 1'b0;
         end
         if (hold_chk) chk("hold_stable", 32'({m_valid, m_data, m_last}), 32'({1'b1, hold_val}));
         if (in_tail) chk("tail_s_ready", 32'(s_ready), 32'd0);
         if (cfg_err) cfg_seen++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               fail("extra_symbol");
            end else begin
               e = exp_q.pop_front();
               chk("symbol", 32'({m_data, m_last}), 32'(e));
               if (e[0]) begin
                  in_tail  = 1'b0;
                  chk_idle = 1'b1;
               end
            end
         end
         hold_chk = m_valid & ~m_ready;
         hold_val = {m_data, m_last};
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit q[$];
      int k;
      int len;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({m_valid, m_data, m_last, s_ready, busy, cfg_err}), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // K=3, bits 1,0,1,1, sink always ready
      rdy_mode = 0;
      q = '{1'b1, 1'b0, 1'b1, 1'b1};
      send_frame(3, q, 0, 3);
      s_valid = 1'b0;
      drain();

      // K=6 single-bit frame
      q = '{1'b1};
      send_frame(6, q, 0, 6);
      s_valid = 1'b0;
      drain();

      // K=3 frame with toggling sink
      rdy_mode = 1;
      q = '{1'b1, 1'b0, 1'b1, 1'b1};
      send_frame(3, q, 0, 3);
      s_valid = 1'b0;
      drain();

      // Illegal K=1 falls back to K=3; mid-frame change to 6 ignored
      rdy_mode = 0;
      q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      send_frame(1, q, 0, 6);
      s_valid = 1'b0;
      drain();

      // Reset during the tail of a K=7 frame, then a clean K=4 frame
      q = '{1'b1};
      send_frame(7, q, 0, 7);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({m_valid, m_data, m_last, s_ready, busy, cfg_err}), 32'd0);
      exp_q.delete();
      in_tail = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      q = '{1'b1};
      send_frame(4, q, 0, 4);
      s_valid = 1'b0;
      drain();

      // Back-to-back frames with s_valid held high
      rdy_mode = 2;
      q = '{1'b1, 1'b1, 1'b0, 1'b1};
      send_frame(5, q, 0, int'($urandom_range(0, 7)));
      q = '{1'b0, 1'b1, 1'b1};
      send_frame(7, q, 0, int'($urandom_range(0, 7)));
      s_valid = 1'b0;
      drain();

      // Randomized frames: K in 0..7, lengths 1..10, random gaps and backpressure
      for (int f = 0; f < 25; f++) begin
         k   = int'($urandom_range(0, 7));
         len = int'($urandom_range(1, 10));
         q.delete();
         for (int b = 0; b < len; b++) q.push_back(1'($urandom_range(0, 1)));
         send_frame(k, q, 2, int'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 0) s_valid = 1'b0;
      end
      s_valid = 1'b0;
      drain();

      chk("cfg_err_pulses", 32'(cfg_seen), 32'(cfg_exp));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
